// File: rtl/argmax_controller.sv
// argmax_controller: streams an activation vector from SDRAM and
// reports the index and value of its largest signed element.
module argmax_controller (
  input  logic        clk,
  input  logic        reset,
  output logic        slave_waitrequest,
  input  logic [2:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [1:0] {IDLE, READ, FINISH} state_t;

  state_t      state, state_nx;
  logic [31:0] src;
  logic [15:0] len;
  logic [15:0] res_idx;
  logic [31:0] res_max;
  logic        done;
  logic [15:0] cnt;
  logic [15:0] run_idx;
  logic [31:0] run_max;
  logic        busy;
  logic        cfg_we;
  logic        start;
  logic        accept;
  logic        last;
  logic        better;

  assign slave_waitrequest = 1'b0;
  assign master_write      = 1'b0;
  assign master_writedata  = '0;

  assign busy   = (state != IDLE);
  assign cfg_we = slave_write && !busy;
  assign start  = cfg_we && (slave_address == 3'd0);
  assign accept = (state == READ) && !master_waitrequest;
  assign last   = (cnt == len - 16'd1);
  assign better = (cnt == 16'd0) ||
                  ($signed(master_readdata) > $signed(run_max));

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and SDRAM request; address holds while stalled.
  always_comb begin
    state_nx       = state;
    master_read    = 1'b0;
    master_address = '0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len == 16'd0) ? FINISH : READ;
      end
      READ: begin
        master_read    = 1'b1;
        master_address = (src + {16'b0, cnt}) << 2;
        if (accept && last)
          state_nx = FINISH;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // CPU-visible configuration, frozen while a run is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src <= '0;
      len <= '0;
    end else if (cfg_we) begin
      if (slave_address == 3'd1) src <= slave_writedata;
      if (slave_address == 3'd2) len <= slave_writedata[15:0];
    end
  end

  // Running maximum search and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      run_idx <= '0;
      run_max <= '0;
      res_idx <= '0;
      res_max <= '0;
      done    <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      run_idx <= '0;
      run_max <= '0;
      done    <= 1'b0;
    end else if (accept) begin
      if (better) begin
        run_idx <= cnt;
        run_max <= master_readdata;
      end
      if (!last) cnt <= cnt + 16'd1;
    end else if (state == FINISH) begin
      res_idx <= run_idx;
      res_max <= run_max;
      done    <= 1'b1;
    end
  end

  // Register read mux, zero when no read strobe.
  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        3'd0:    slave_readdata = {30'b0, done, busy};
        3'd1:    slave_readdata = src;
        3'd2:    slave_readdata = {16'b0, len};
        3'd3:    slave_readdata = {16'b0, res_idx};
        3'd4:    slave_readdata = res_max;
        default: slave_readdata = '0;
      endcase
    end
  end

endmodule
